// File: rtl/hangman_pkg.sv
// Shared encodings and defaults for the Hangman game controllers.
package hangman_pkg;

  localparam int unsigned STATE_W         = 3;
  localparam int unsigned CNT_W           = 4;
  localparam int unsigned DEF_RESULT_HOLD = 250000000;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_INGAME   = 3'd1,
    ST_PAUSED   = 3'd2,
    ST_WIN      = 3'd3,
    ST_LOST     = 3'd4,
    ST_MATCHEND = 3'd5
  } state_t;

  // States that dwell on the timed result screen
  function automatic logic is_hold(input state_t s);
    return (s == ST_WIN) || (s == ST_LOST) || (s == ST_MATCHEND);
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter for timed screens; done_c flags a zero count.
module hold_timer #(
  parameter int unsigned HOLD_W = 28
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [HOLD_W-1:0] load_val,
  input  logic              en,
  output logic              done_c
);

  logic [HOLD_W-1:0] cnt;

  // Load wins over decrement; count stops at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - HOLD_W'(1);
    end
  end

  assign done_c = (cnt == '0);

endmodule

// File: rtl/hangman_match_ctrl.sv
// Best-of-ROUNDS Hangman match sequencer: lives, pause, tallies, timed result screens.
module hangman_match_ctrl
  import hangman_pkg::*;
#(
  parameter int unsigned RESULT_HOLD = DEF_RESULT_HOLD,
  parameter int unsigned MAX_LIVES   = 6,
  parameter int unsigned ROUNDS      = 3,
  parameter int unsigned HOLD_W      = 28
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_game,
  input  logic               pause_toggle,
  input  logic               guess_valid,
  input  logic               guess_hit,
  input  logic               word_done,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   lives_left,
  output logic [CNT_W-1:0]   round_num,
  output logic [CNT_W-1:0]   wins,
  output logic [CNT_W-1:0]   losses,
  output logic               result_pulse,
  output logic               match_over
);

  localparam logic [CNT_W-1:0]  LIVES_INIT = CNT_W'(MAX_LIVES);
  localparam logic [CNT_W-1:0]  HALF       = CNT_W'(ROUNDS / 2);
  localparam logic [CNT_W-1:0]  LAST_ROUND = CNT_W'(ROUNDS);
  localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(RESULT_HOLD - 1);

  state_t           st, st_nxt;
  logic [CNT_W-1:0] lives_nxt, round_nxt, wins_nxt, losses_nxt;
  logic             pulse_nxt;
  logic             tmr_load, tmr_en, tmr_done_c;
  logic             miss_c, decided_c;

  hold_timer #(.HOLD_W(HOLD_W)) u_hold_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (HOLD_LOAD),
    .en       (tmr_en),
    .done_c   (tmr_done_c)
  );

  // Next state, counter updates and timer control
  always_comb begin
    st_nxt     = st;
    lives_nxt  = lives_left;
    round_nxt  = round_num;
    wins_nxt   = wins;
    losses_nxt = losses;
    pulse_nxt  = 1'b0;
    tmr_en     = 1'b0;
    miss_c     = guess_valid && !guess_hit;
    decided_c  = (wins > HALF) || (losses > HALF) || (round_num == LAST_ROUND);

    case (st)
      ST_IDLE: begin
        if (start_game) begin
          st_nxt    = ST_INGAME;
          round_nxt = round_num + CNT_W'(1);
          lives_nxt = LIVES_INIT;
        end
      end
      ST_INGAME: begin
        if (word_done) begin
          st_nxt    = ST_WIN;
          wins_nxt  = wins + CNT_W'(1);
          pulse_nxt = 1'b1;
        end else if (miss_c && (lives_left <= CNT_W'(1))) begin
          st_nxt     = ST_LOST;
          lives_nxt  = '0;
          losses_nxt = losses + CNT_W'(1);
          pulse_nxt  = 1'b1;
        end else if (miss_c) begin
          lives_nxt = lives_left - CNT_W'(1);
        end else if (pause_toggle) begin
          st_nxt = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (pause_toggle) begin
          st_nxt = ST_INGAME;
        end
      end
      ST_WIN, ST_LOST: begin
        if (tmr_done_c) begin
          st_nxt = decided_c ? ST_MATCHEND : ST_IDLE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_MATCHEND: begin
        if (tmr_done_c) begin
          st_nxt     = ST_IDLE;
          round_nxt  = '0;
          wins_nxt   = '0;
          losses_nxt = '0;
          lives_nxt  = LIVES_INIT;
        end else begin
          tmr_en = 1'b1;
        end
      end
      default: begin
        st_nxt = ST_IDLE;
      end
    endcase

    // Reload the dwell timer on every edge that enters a result screen
    tmr_load = is_hold(st_nxt) && (st_nxt != st);
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      st           <= ST_IDLE;
      lives_left   <= LIVES_INIT;
      round_num    <= '0;
      wins         <= '0;
      losses       <= '0;
      result_pulse <= 1'b0;
      match_over   <= 1'b0;
    end else begin
      st           <= st_nxt;
      lives_left   <= lives_nxt;
      round_num    <= round_nxt;
      wins         <= wins_nxt;
      losses       <= losses_nxt;
      result_pulse <= pulse_nxt;
      match_over   <= (st_nxt == ST_MATCHEND);
    end
  end

  assign state = st;

endmodule

// File: tb/tb_hangman_match_ctrl.sv
// Directed bench for hangman_match_ctrl (RESULT_HOLD=4, MAX_LIVES=3, ROUNDS=3).
module tb_hangman_match_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_game, pause_toggle, guess_valid, guess_hit, word_done;
  logic [2:0] state;
  logic [3:0] lives_left, round_num, wins, losses;
  logic       result_pulse, match_over;

  int checks   = 0;
  int failures = 0;

  hangman_match_ctrl #(
    .RESULT_HOLD (4),
    .MAX_LIVES   (3),
    .ROUNDS      (3),
    .HOLD_W      (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start_game   (start_game),
    .pause_toggle (pause_toggle),
    .guess_valid  (guess_valid),
    .guess_hit    (guess_hit),
    .word_done    (word_done),
    .state        (state),
    .lives_left   (lives_left),
    .round_num    (round_num),
    .wins         (wins),
    .losses       (losses),
    .result_pulse (result_pulse),
    .match_over   (match_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Full output snapshot
  task automatic chk_all(input string tag, input int st, input int lv, input int rn,
                         input int w, input int l, input int p, input int mo);
    chk({tag, ".state"},  32'(state),        st);
    chk({tag, ".lives"},  32'(lives_left),   lv);
    chk({tag, ".round"},  32'(round_num),    rn);
    chk({tag, ".wins"},   32'(wins),         w);
    chk({tag, ".losses"}, 32'(losses),       l);
    chk({tag, ".pulse"},  32'(result_pulse), p);
    chk({tag, ".mover"},  32'(match_over),   mo);
  endtask

  task automatic set_in(input logic sg, input logic pt, input logic gv, input logic gh, input logic wd);
    start_game   = sg;
    pause_toggle = pt;
    guess_valid  = gv;
    guess_hit    = gh;
    word_done    = wd;
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0);
    tick(2);
    chk_all("reset", 0, 3, 0, 0, 0, 0, 0);
    reset = 1'b0;

    // Round 1: three misses lose the round
    set_in(1, 0, 0, 0, 0); tick();
    chk_all("r1_start", 1, 3, 1, 0, 0, 0, 0);
    set_in(0, 0, 1, 0, 0); tick();
    chk("miss1.lives", 32'(lives_left), 2);
    tick();
    chk("miss2.lives", 32'(lives_left), 1);
    chk("miss2.state", 32'(state), 1);
    tick();
    chk_all("lost_entry", 4, 0, 1, 0, 1, 1, 0);
    set_in(0, 0, 0, 0, 0); tick();
    chk("lost_h2.pulse", 32'(result_pulse), 0);
    chk("lost_h2.state", 32'(state), 4);
    tick(2);
    chk("lost_h4.state", 32'(state), 4);
    tick();
    chk_all("lost_exit", 0, 0, 1, 0, 1, 0, 0);

    // Round 2: word_done beats a simultaneous miss
    set_in(1, 0, 0, 0, 0); tick();
    chk_all("r2_start", 1, 3, 2, 0, 1, 0, 0);
    set_in(0, 0, 1, 0, 1); tick();
    chk_all("win_entry", 3, 3, 2, 1, 1, 1, 0);
    set_in(0, 0, 0, 0, 0); tick(3);
    chk("win_h4.state", 32'(state), 3);
    tick();
    chk_all("win_exit", 0, 3, 2, 1, 1, 0, 0);

    // Round 3: pause freezes the round, miss beats pause, hit is a no-op
    set_in(1, 0, 0, 0, 0); tick();
    chk_all("r3_start", 1, 3, 3, 1, 1, 0, 0);
    set_in(0, 1, 0, 0, 0); tick();
    chk("pause.state", 32'(state), 2);
    set_in(0, 0, 1, 0, 1); tick();
    chk("paused_in1.state", 32'(state), 2);
    tick();
    chk_all("paused_in2", 2, 3, 3, 1, 1, 0, 0);
    set_in(0, 1, 0, 0, 0); tick();
    chk_all("resume", 1, 3, 3, 1, 1, 0, 0);
    set_in(0, 1, 1, 0, 0); tick();
    chk("miss_pause.state", 32'(state), 1);
    chk("miss_pause.lives", 32'(lives_left), 2);
    set_in(0, 0, 1, 1, 0); tick();
    chk("hit.lives", 32'(lives_left), 2);
    chk("hit.state", 32'(state), 1);
    set_in(0, 0, 0, 0, 1); tick();
    chk_all("r3_win", 3, 2, 3, 2, 1, 1, 0);
    set_in(0, 0, 0, 0, 0); tick(3);
    chk("r3_hold.state", 32'(state), 3);
    tick();
    chk_all("me_last_round", 5, 2, 3, 2, 1, 0, 1);
    tick(3);
    chk("me_h4.state", 32'(state), 5);
    chk("me_h4.mover", 32'(match_over), 1);
    tick();
    chk_all("me_exit", 0, 3, 0, 0, 0, 0, 0);

    // Fresh match: two wins decide it early
    set_in(1, 0, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 1); tick();
    chk_all("m2_w1", 3, 3, 1, 1, 0, 1, 0);
    set_in(0, 0, 0, 0, 0); tick(4);
    chk("m2_w1_exit.state", 32'(state), 0);
    set_in(1, 0, 0, 0, 0); tick();
    chk("m2_r2.round", 32'(round_num), 2);
    set_in(0, 0, 0, 0, 1); tick();
    chk_all("m2_w2", 3, 3, 2, 2, 0, 1, 0);
    set_in(0, 0, 0, 0, 0); tick(4);
    chk_all("m2_me", 5, 3, 2, 2, 0, 0, 1);
    tick(3);
    chk("m2_me_h4.state", 32'(state), 5);
    tick();
    chk_all("m2_me_exit", 0, 3, 0, 0, 0, 0, 0);

    // Reset during the second cycle of a WIN hold
    set_in(1, 0, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 1); tick();
    set_in(0, 0, 0, 0, 0); tick();
    chk_all("rst_w_h2", 3, 3, 1, 1, 0, 0, 0);
    reset = 1'b1; tick();
    chk_all("rst_mid_hold", 0, 3, 0, 0, 0, 0, 0);
    reset = 1'b0;

    // start_game held high: rounds chain back to back
    set_in(1, 0, 0, 0, 0); tick();
    chk("lvl_r1.round", 32'(round_num), 1);
    set_in(1, 0, 0, 0, 1); tick();
    chk_all("lvl_w1", 3, 3, 1, 1, 0, 1, 0);
    set_in(1, 0, 0, 0, 0); tick(3);
    chk("lvl_w1_h4.state", 32'(state), 3);
    tick();
    chk_all("lvl_idle", 0, 3, 1, 1, 0, 0, 0);
    tick();
    chk_all("lvl_r2", 1, 3, 2, 1, 0, 0, 0);
    set_in(1, 0, 1, 0, 0); tick(3);
    chk_all("lvl_lost", 4, 0, 2, 1, 1, 1, 0);
    tick(3);
    chk("lvl_lost_h4.state", 32'(state), 4);
    chk("lvl_lost_h4.losses", 32'(losses), 1);
    set_in(1, 0, 0, 0, 0); tick();
    chk("lvl_idle2.state", 32'(state), 0);
    tick();
    chk_all("lvl_r3", 1, 3, 3, 1, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
